// File: rtl/pe_seq_ctrl.sv
// pe_seq_ctrl: streams neuron/weight chunks into one parallel_pe and writes its results to the output buffer.
// Optional busy-cycle counter is built when PE_SEQ_CTRL_PERF_EN is defined.
module pe_seq_ctrl #(
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  vec_len,
  input  logic [LEN_W-1:0]  out_num,
  output logic              busy,
  output logic              done,
  output logic              nbuf_ren,
  output logic [ADDR_W-1:0] nbuf_raddr,
  output logic              wbuf_ren,
  output logic [ADDR_W-1:0] wbuf_raddr,
  output logic              pe_vld_i,
  output logic [1:0]        pe_ctl,
  input  logic              pe_vld_o,
  input  logic [31:0]       pe_result,
  output logic              obuf_wen,
  output logic [LEN_W-1:0]  obuf_waddr,
  output logic [31:0]       obuf_wdata,
  output logic [31:0]       perf_cycles
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, state_nx;
  logic [LEN_W-1:0] len_q, num_q, c, o, w;
  logic [ADDR_W-1:0] wa;
  logic run, go, c_last, o_last, w_last;
  assign run = state == RUN;
  assign go = state == IDLE && start && vec_len != '0 && out_num != '0;
  assign c_last = c == len_q - LEN_W'(1);
  assign o_last = o == num_q - LEN_W'(1);
  assign w_last = w == num_q - LEN_W'(1);
  assign busy = run || state == DRAIN;
  assign done = state == DONE;
  assign nbuf_ren = run;
  assign wbuf_ren = run;
  assign nbuf_raddr = ADDR_W'(c);
  assign wbuf_raddr = wa;
  assign obuf_wen = pe_vld_o && busy;
  assign obuf_waddr = w;
  assign obuf_wdata = obuf_wen ? pe_result : '0;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = go ? RUN : DONE;
      RUN:     if (c_last && o_last) state_nx = DRAIN;
      DRAIN:   if (obuf_wen && w_last) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // Counters wrap back to 0 at their last step so IDLE always presents zero addresses.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      len_q    <= '0;
      num_q    <= '0;
      c        <= '0;
      o        <= '0;
      w        <= '0;
      wa       <= '0;
      pe_vld_i <= 1'b0;
      pe_ctl   <= 2'b00;
    end else begin
      if (go) begin
        len_q <= vec_len;
        num_q <= out_num;
      end
      if (run) begin
        c  <= c_last ? '0 : c + LEN_W'(1);
        wa <= (c_last && o_last) ? '0 : wa + ADDR_W'(1);
        if (c_last) o <= o_last ? '0 : o + LEN_W'(1);
      end
      if (obuf_wen) w <= w_last ? '0 : w + LEN_W'(1);
      pe_vld_i <= run;
      pe_ctl   <= run ? {c_last, c == '0} : 2'b00;
    end
`ifdef PE_SEQ_CTRL_PERF_EN
  logic [31:0] perf_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) perf_q <= '0;
    else if (go) perf_q <= '0;
    else if (busy && perf_q != '1) perf_q <= perf_q + 32'd1;
  assign perf_cycles = perf_q;
`else
  assign perf_cycles = '0;
`endif
endmodule

// File: tb/tb_pe_seq_ctrl.sv
// tb_pe_seq_ctrl: table-driven and randomized jobs against a spec-level model of reads, PE control and writes.
module tb_pe_seq_ctrl;
  logic clk = 1'b0;
  logic rst_n, start, busy, done, nbuf_ren, wbuf_ren, pe_vld_i, pe_vld_o, obuf_wen;
  logic [7:0] vec_len, out_num, obuf_waddr;
  logic [9:0] nbuf_raddr, wbuf_raddr;
  logic [1:0] pe_ctl;
  logic [31:0] pe_result, obuf_wdata, perf_cycles;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;

  pe_seq_ctrl #(.ADDR_W(10), .LEN_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .vec_len(vec_len), .out_num(out_num),
    .busy(busy), .done(done), .nbuf_ren(nbuf_ren), .nbuf_raddr(nbuf_raddr),
    .wbuf_ren(wbuf_ren), .wbuf_raddr(wbuf_raddr), .pe_vld_i(pe_vld_i), .pe_ctl(pe_ctl),
    .pe_vld_o(pe_vld_o), .pe_result(pe_result), .obuf_wen(obuf_wen),
    .obuf_waddr(obuf_waddr), .obuf_wdata(obuf_wdata), .perf_cycles(perf_cycles)
  );

  // Buffers with 1-cycle read latency and a stand-in PE (32-bit lanes instead of 512-bit chunks).
  logic [31:0] nmem [1024];
  logic [31:0] wmem [1024];
  logic [31:0] nd, wd, psum, res_m, acc;
  logic vo_m, force_vo;
  assign acc = (pe_ctl[0] ? 32'd0 : psum) + nd * wd;
  assign pe_vld_o = vo_m | force_vo;
  assign pe_result = force_vo ? 32'hDEAD_BEEF : res_m;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      nd <= 0; wd <= 0; psum <= 0; res_m <= 0; vo_m <= 0;
    end else begin
      if (nbuf_ren) nd <= nmem[nbuf_raddr];
      if (wbuf_ren) wd <= wmem[wbuf_raddr];
      vo_m <= 1'b0;
      if (pe_vld_i) begin
        psum <= acc;
        if (pe_ctl[1]) begin vo_m <= 1'b1; res_m <= acc; end
      end
    end

  typedef struct {int len; int num; int lat; int mode;} vec_t;
  vec_t tbl[8];

  task automatic chk(input string nm, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".done"}, done, 0);
    chk({tag, ".nbuf_ren"}, nbuf_ren, 0);
    chk({tag, ".nbuf_raddr"}, nbuf_raddr, 0);
    chk({tag, ".wbuf_ren"}, wbuf_ren, 0);
    chk({tag, ".wbuf_raddr"}, wbuf_raddr, 0);
    chk({tag, ".pe_vld_i"}, pe_vld_i, 0);
    chk({tag, ".pe_ctl"}, pe_ctl, 0);
    chk({tag, ".obuf_wen"}, obuf_wen, 0);
    chk({tag, ".obuf_waddr"}, obuf_waddr, 0);
    chk({tag, ".obuf_wdata"}, obuf_wdata, 0);
    chk({tag, ".perf_cycles"}, perf_cycles, 0);
  endtask

  // mode 0: plain job; 1: start re-pulsed mid-RUN with other config; 2: start pulsed in the DONE cycle.
  task automatic run_job(input int len, input int num, input int lat, input int mode);
    int n, ri, ci, wi, bz, dk, l;
    bit degen;
    logic [31:0] s;
    logic [31:0] exp_d[$];
    n = len * num;
    degen = (len == 0) || (num == 0);
    ri = 0; ci = 0; wi = 0; bz = 0; dk = -1;
    for (int k = 0; k < num; k++) begin
      s = 0;
      for (int j = 0; j < len; j++) s += nmem[j] * wmem[(k * len + j) % 1024];
      exp_d.push_back(s);
    end
    l = degen ? 1 : len;
    @(negedge clk);
    vec_len = 8'(len); out_num = 8'(num); start = 1'b1;
    for (int k = 1; k <= lat + 5; k++) begin
      @(negedge clk);
      start = (mode == 1 && k == 3);
      if (start) begin vec_len = 8'd1; out_num = 8'd7; end
`ifndef PE_SEQ_CTRL_PERF_EN
      chk("perf_off", perf_cycles, 0);
`endif
      chk("ren_pair", wbuf_ren, nbuf_ren);
      if (nbuf_ren) begin
        chk("read_cycle", k, ri + 1);
        chk("nbuf_raddr", nbuf_raddr, ri % l);
        chk("wbuf_raddr", wbuf_raddr, ri % 1024);
        ri++;
      end
      if (pe_vld_i) begin
        chk("vld_i_cycle", k, ci + 2);
        chk("pe_ctl", pe_ctl, 2 * int'((ci % l) == l - 1) + int'((ci % l) == 0));
        ci++;
      end
      if (obuf_wen) begin
        chk("obuf_waddr", obuf_waddr, wi);
        chk("obuf_wdata", obuf_wdata, wi < exp_d.size() ? exp_d[wi] : 32'hFFFF_FFFF);
        wi++;
      end
      if (busy) bz++;
      if (done) begin dk = k; break; end
    end
    if (dk < 0) begin
      failures++;
      $display("FAIL done_timeout len=%0d num=%0d got=none exp=%0d", len, num, lat);
    end
    chk("done_latency", dk, lat);
    chk("busy_at_done", busy, 0);
    chk("read_count", ri, degen ? 0 : n);
    chk("vld_i_count", ci, degen ? 0 : n);
    chk("write_count", wi, degen ? 0 : num);
    chk("busy_cycles", bz, degen ? 0 : n + 2);
`ifdef PE_SEQ_CTRL_PERF_EN
    if (!degen) chk("perf_at_done", perf_cycles, n + 2);
`endif
    if (mode == 2) begin
      start = 1'b1; vec_len = 8'd2; out_num = 8'd2;
    end
    @(negedge clk);
    start = 1'b0;
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
`ifdef PE_SEQ_CTRL_PERF_EN
    if (!degen) chk("perf_hold", perf_cycles, n + 2);
`endif
    if (mode == 2) begin
      @(negedge clk);
      chk("done_start_ignored_busy", busy, 0);
      chk("done_start_ignored_ren", nbuf_ren, 0);
    end
  endtask

  initial begin
    tbl[0] = '{4, 2, 11, 0};
    tbl[1] = '{1, 3, 6, 0};
    tbl[2] = '{0, 5, 1, 0};
    tbl[3] = '{3, 0, 1, 0};
    tbl[4] = '{4, 2, 11, 1};
    tbl[5] = '{2, 3, 9, 2};
    tbl[6] = '{200, 6, 1203, 0};
    tbl[7] = '{1, 1, 4, 0};
    for (int i = 0; i < 1024; i++) begin
      nmem[i] = $urandom;
      wmem[i] = $urandom;
    end
    rst_n = 1'b0; start = 1'b0; vec_len = 0; out_num = 0; force_vo = 1'b0;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) run_job(tbl[i].len, tbl[i].num, tbl[i].lat, tbl[i].mode);
    // Stray PE result while idle must not write or move the write index.
    @(negedge clk);
    force_vo = 1'b1;
    #1 chk("stray_wen", obuf_wen, 0);
    @(negedge clk);
    chk("stray_waddr", obuf_waddr, 0);
    force_vo = 1'b0;
    // Reset in the middle of a job, then a fresh job from address 0.
    @(negedge clk);
    vec_len = 8'd4; out_num = 8'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("busy_before_rst", busy, 1);
    rst_n = 1'b0; force_vo = 1'b1;
    #1 chk_zero("rst_mid");
    @(negedge clk);
    chk_zero("rst_hold");
    rst_n = 1'b1; force_vo = 1'b0;
    run_job(2, 1, 5, 0);
    for (int i = 0; i < 8; i++) begin
      int len, num;
      len = int'($urandom_range(1, 6));
      num = int'($urandom_range(1, 5));
      run_job(len, num, len * num + 3, int'($urandom_range(0, 1)));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
